ifetch_queue: RTL

- Instruction-fetch front end between instruction memory and the execute stage.
- Generates sequential word addresses, issues reads to a 1-cycle-latency instruction memory, and buffers returned words with their PCs in a DEPTH-entry FIFO.
- Presents instructions to execute through a valid/ready handshake.
- Accepts a redirect (taken branch, jump, jr) that flushes buffered and in-flight fetches and restarts at the target.

---
 rtl/ifetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch into a DEPTH-entry FIFO with redirect flush.
// Optional IFQ_STATS_EN adds saturating stall/flush counters (stall_cnt, flush_cnt).
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     rstd,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_ins,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rsp_pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] pc_mem  [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic          unused_rpc_hi;

  assign unused_rpc_hi = ^redirect_pc[31:AW];

  // Credits count the in-flight read so a returning word always has a free slot.
  assign used      = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue     = !rstd && !redirect && (used < (CW+1)'(DEPTH));
  assign push      = inflight_q && !redirect;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign out_ins   = ins_mem[rd_ptr_q];
  assign out_pc    = 32'(pc_mem[rd_ptr_q]);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + AW'(1);
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc[AW-1:0];
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Response stage: the PC of the issued read travels one cycle behind the request.
  always_ff @(posedge clk) begin
    if (issue) rsp_pc_q <= fetch_pc_q;
    if (push) begin
      ins_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]  <= rsp_pc_q;
    end
  end

`ifdef IFQ_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rstd) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_ready && !out_valid) stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (redirect)                flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
